// File: rtl/monitor_buffer.sv
// rtl/monitor_buffer.sv - occupancy FSM, event pulses, saturating counters and alarm for the buffer/timer stage
module monitor_buffer #(
  parameter int FULL_LEVEL = 12,
  parameter int TIMER_MAX  = 27,
  parameter int ALARM_HOLD = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic [4:0] timer_in,
  input  logic       ack,
  output logic [1:0] state,
  output logic       full,
  output logic       alarm,
  output logic       wrap_pulse,
  output logic       drop_pulse,
  output logic       tick_pulse,
  output logic [7:0] cycles,
  output logic [7:0] frames,
  output logic       error
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILLING = 2'd1, FULL = 2'd2, ALARM = 2'd3} state_t;

  localparam logic [3:0] FULL_C = 4'(FULL_LEVEL);
  localparam logic [4:0] TMAX_C = 5'(TIMER_MAX);
  localparam logic [4:0] HOLD_C = 5'(ALARM_HOLD);

  state_t     st, st_nxt, st_base;
  logic [3:0] count_q, hold_cnt, hold_nxt;
  logic [4:0] timer_q;
  logic       c_full, c_zero, c_over, t_over;
  logic       wrap_ev, drop_ev, tick_ev, hold_hit, ack_alarm;

  assign c_full    = (count_in == FULL_C);
  assign c_zero    = (count_in == 4'd0);
  assign c_over    = (count_in > FULL_C);
  assign t_over    = (timer_in > TMAX_C);
  assign wrap_ev   = (count_q == FULL_C) && c_zero;
  assign drop_ev   = (count_q != 4'd0) && (count_q < FULL_C) && c_zero;
  assign tick_ev   = (timer_q == TMAX_C) && (timer_in == 5'd0);
  assign hold_hit  = ({1'b0, hold_cnt} + 5'd1) >= HOLD_C;
  assign ack_alarm = (st == ALARM) && ack;

  always_comb begin
    st_base = FILLING;
    if (c_zero)      st_base = IDLE;
    else if (c_full) st_base = FULL;

    st_nxt = st_base;
    if (st == ALARM) begin
      if (!ack) st_nxt = ALARM;
    end else if (c_full && hold_hit) begin
      st_nxt = ALARM;
    end

    // acknowledge restarts the full-duration count even if the buffer stays full
    hold_nxt = 4'd0;
    if (!ack_alarm && c_full) hold_nxt = (hold_cnt == 4'hF) ? 4'hF : hold_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= 4'd0;
      timer_q    <= 5'd0;
      hold_cnt   <= 4'd0;
      st         <= IDLE;
      full       <= 1'b0;
      alarm      <= 1'b0;
      wrap_pulse <= 1'b0;
      drop_pulse <= 1'b0;
      tick_pulse <= 1'b0;
      cycles     <= 8'd0;
      frames     <= 8'd0;
      error      <= 1'b0;
    end else begin
      count_q    <= count_in;
      timer_q    <= timer_in;
      hold_cnt   <= hold_nxt;
      st         <= st_nxt;
      full       <= c_full;
      alarm      <= (st_nxt == ALARM);
      wrap_pulse <= wrap_ev;
      drop_pulse <= drop_ev;
      tick_pulse <= tick_ev;
      if (wrap_ev && cycles != 8'hFF) cycles <= cycles + 8'd1;
      if (tick_ev && frames != 8'hFF) frames <= frames + 8'd1;
      error      <= error | c_over | t_over;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_monitor_buffer.sv
// tb/tb_monitor_buffer.sv - directed self-checking bench for monitor_buffer
module tb_monitor_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic [4:0] timer_in;
  logic       ack;
  logic [1:0] state;
  logic       full, alarm, wrap_pulse, drop_pulse, tick_pulse, error;
  logic [7:0] cycles, frames;

  int tests = 0;
  int fails = 0;

  monitor_buffer dut (
    .clk(clk), .reset(reset), .count_in(count_in), .timer_in(timer_in), .ack(ack),
    .state(state), .full(full), .alarm(alarm), .wrap_pulse(wrap_pulse),
    .drop_pulse(drop_pulse), .tick_pulse(tick_pulse), .cycles(cycles),
    .frames(frames), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // apply one sample, clock it in, and settle 1ns past the edge
  task automatic cyc(input logic [3:0] c, input logic [4:0] t, input logic a);
    count_in = c;
    timer_in = t;
    ack      = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    count_in = 4'd0;
    timer_in = 5'd0;
    ack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {state, full, alarm, wrap_pulse, drop_pulse, tick_pulse, error, cycles, frames}, 32'd0);
  endtask

  initial begin
    int prev_c, prev_t, exp_fr, exp_cy;
    logic alarm_seen;

    do_reset();
    check_all_zero("reset_state");

    // count ramp 0..12 then 0
    alarm_seen = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      cyc(4'(i), 5'd0, 1'b0);
      check("ramp_state", state, (i == 0) ? 0 : (i == 12) ? 2 : 1);
      alarm_seen |= alarm;
    end
    check("ramp_full", full, 1);
    cyc(4'd0, 5'd0, 1'b0);
    check("ramp_wrap", wrap_pulse, 1);
    check("ramp_cycles", cycles, 1);
    check("ramp_state0", state, 0);
    check("ramp_noalarm", alarm_seen, 0);
    cyc(4'd0, 5'd0, 1'b0);
    check("wrap_one_cycle", wrap_pulse, 0);

    // held full -> alarm on 3rd sample
    cyc(4'd12, 5'd0, 1'b0); check("hold1_state", state, 2);
    cyc(4'd12, 5'd0, 1'b0); check("hold2_state", state, 2);
    cyc(4'd12, 5'd0, 1'b0); check("hold3_state", state, 3); check("hold3_alarm", alarm, 1);
    cyc(4'd12, 5'd0, 1'b0); check("hold4_state", state, 3);
    cyc(4'd12, 5'd1, 1'b0); check("hold5_state", state, 3);
    cyc(4'd12, 5'd0, 1'b1); check("ack_state", state, 2); check("ack_alarm", alarm, 0);
    cyc(4'd12, 5'd0, 1'b0); check("rehold1", state, 2);
    cyc(4'd12, 5'd0, 1'b0); check("rehold2", state, 2);
    cyc(4'd12, 5'd0, 1'b0); check("rehold3", state, 3);
    // ack and wrap on the same edge
    cyc(4'd0, 5'd0, 1'b1);
    check("ackwrap_state", state, 0);
    check("ackwrap_pulse", wrap_pulse, 1);
    check("ackwrap_cycles", cycles, 2);

    // premature drop
    cyc(4'd7, 5'd0, 1'b0); check("drop_pre", state, 1);
    cyc(4'd0, 5'd0, 1'b0);
    check("drop_pulse", drop_pulse, 1);
    check("drop_nowrap", wrap_pulse, 0);
    check("drop_cycles", cycles, 2);
    check("drop_state", state, 0);
    cyc(4'd0, 5'd0, 1'b0); check("drop_one_cycle", drop_pulse, 0);

    // free-running count and timer, aligned at zero
    prev_c = 0; prev_t = 0; exp_fr = 0; exp_cy = 2;
    for (int i = 0; i < 300 * 28; i++) begin
      cyc(4'(i % 13), 5'(i % 28), 1'b0);
      check("run_tick", tick_pulse, (prev_t == 27 && i % 28 == 0) ? 1 : 0);
      check("run_wrap", wrap_pulse, (prev_c == 12 && i % 13 == 0) ? 1 : 0);
      if (prev_t == 27 && i % 28 == 0 && exp_fr < 255) exp_fr++;
      if (prev_c == 12 && i % 13 == 0 && exp_cy < 255) exp_cy++;
      prev_c = i % 13; prev_t = i % 28;
      if (i == 280) check("frames_10", frames, 10);
      if (i == 364) begin
        check("both_wrap", wrap_pulse, 1);
        check("both_tick", tick_pulse, 1);
        check("cycles_364", cycles, 30);
        check("frames_364", frames, 13);
      end
      if (alarm) check("run_alarm", alarm, 0);
    end
    check("frames_sat", frames, 255);
    check("cycles_sat", cycles, 255);
    check("frames_model", frames, exp_fr);
    check("cycles_model", cycles, exp_cy);

    // out-of-range count is sticky
    cyc(4'd0, 5'd0, 1'b0);
    check("err_before", error, 0);
    cyc(4'd14, 5'd0, 1'b0);
    check("err_set", error, 1);
    check("err_state", state, 1);
    cyc(4'd0, 5'd0, 1'b0);
    check("err_nodrop", drop_pulse, 0);
    for (int i = 1; i <= 5; i++) cyc(4'(i), 5'd0, 1'b0);
    check("err_sticky", error, 1);
    cyc(4'd3, 5'd29, 1'b0);
    check("err_timer", error, 1);

    // async reset while in ALARM with cycles=4
    do_reset();
    check_all_zero("reset2_state");
    cyc(4'd0, 5'd1, 1'b0);
    check("tmr_err_clear", error, 0);
    cyc(4'd0, 5'd28, 1'b0);
    check("tmr_err_set", error, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(4'd12, 5'd0, 1'b0);
      cyc(4'd0, 5'd0, 1'b0);
    end
    cyc(4'd12, 5'd0, 1'b0);
    cyc(4'd12, 5'd0, 1'b0);
    cyc(4'd12, 5'd0, 1'b0);
    check("pre_rst_state", state, 3);
    check("pre_rst_cycles", cycles, 4);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    count_in = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(4'd0, 5'd0, 1'b0);
    check("post_rst_pulses", {wrap_pulse, drop_pulse, tick_pulse}, 0);
    check("post_rst_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/monitor_buffer.md
# monitor_buffer

Downstream observer for the 0–12 buffer counter and 0–27 timer stage. Samples `count_in`/`timer_in` every clock and tracks buffer occupancy with a 4-state FSM. Emits one-cycle event pulses on counter wrap, premature drop to zero, and timer wrap, and keeps saturating event counters. Raises an acknowledged alarm when the buffer stays full too long, and flags out-of-range inputs.

## Interface
- `FULL_LEVEL`, 12, count value treated as full / wrap point
- `TIMER_MAX`, 27, timer value preceding timer wrap
- `ALARM_HOLD`, 3, consecutive full samples that trigger alarm (range 1–15)
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; low forces all registers to reset values immediately
- `count_in`  in  4  upstream buffer count
- `timer_in`  in  5  upstream timer
- `ack`  in  1  alarm acknowledge, level sampled on clock edge
- `state`  out  2  FSM state: IDLE=0, FILLING=1, FULL=2, ALARM=3
- `full`  out  1  high while last sampled `count_in` == FULL_LEVEL
- `alarm`  out  1  high while state == ALARM
- `wrap_pulse`  out  1  one cycle: count went FULL_LEVEL -> 0
- `drop_pulse`  out  1  one cycle: count went 1..FULL_LEVEL-1 -> 0
- `tick_pulse`  out  1  one cycle: timer went TIMER_MAX -> 0
- `cycles`  out  8  number of wrap_pulse events, saturating at 255
- `frames`  out  8  number of tick_pulse events, saturating at 255
- `error`  out  1  sticky out-of-range flag

## Operation
- Registers `count_q`, `timer_q` hold the previous sample. Every edge compares the new inputs against them, then loads them.
- Reset values: `count_q`=0, `timer_q`=0, `hold_cnt`=0, state=IDLE, all outputs 0.
- Event detection at each edge, using the new sample `c`/`t` and previous `count_q`/`timer_q`:
  - `wrap_pulse` <= (`count_q`==FULL_LEVEL && `c`==0).
  - `drop_pulse` <= (`count_q` in 1..FULL_LEVEL-1 && `c`==0).
  - `tick_pulse` <= (`timer_q`==TIMER_MAX && `t`==0).
  - Other transitions (hold, +1, 0->0) produce no pulse.
- `cycles`/`frames` increment on the same edge their pulse is set; hold at 255.
- `full` <= (`c`==FULL_LEVEL).
- `hold_cnt` (4 bit): when `c`==FULL_LEVEL it increments, saturating at 15; otherwise it is set to 0.
- FSM, evaluated every edge:
  - Not in ALARM, with `c`==FULL_LEVEL and `hold_cnt`+1 >= ALARM_HOLD: go to ALARM.
  - Otherwise, not in ALARM: `c`==0 -> IDLE; 1..FULL_LEVEL-1 -> FILLING; FULL_LEVEL -> FULL.
  - ALARM with `ack`=0: stay in ALARM; pulses and counters keep running.
  - ALARM with `ack`=1: leave to IDLE/FILLING/FULL per `c`, and clear `hold_cnt` to 0. If count stays full, ALARM re-enters after ALARM_HOLD further full samples.
  - `ack` outside ALARM: ignored.
- `error` <= `error` | (`c` > FULL_LEVEL) | (`t` > TIMER_MAX); cleared only by `reset`. Out-of-range samples still drive the FSM (count > FULL_LEVEL -> FILLING) and are still loaded into `count_q`/`timer_q`.

## Timing
- Input change visible after edge k is sampled at edge k+1; the resulting outputs are valid from edge k+1 to edge k+2 (1-cycle latency).
- Pulses are exactly one cycle wide; back-to-back events give back-to-back pulses.
- Simultaneous events are independent:
  - `wrap_pulse` and `tick_pulse` in the same cycle both assert, and both counters increment.
  - `ack` and a wrap in the same edge both take effect.
- `reset` asserted mid-operation: all outputs drop asynchronously to reset values. After release, the first sample compares against `count_q`=0, so no false wrap or drop pulse is produced.
- With upstream `start` held high, count sits at 12 for one sample only, so no alarm occurs for ALARM_HOLD >= 2.

## Test plan
- Reset, then count 0..12,0 with start held high -> state 0->1…->2->0, one `wrap_pulse` one cycle after 0 is sampled, `cycles`=1, `alarm` never asserts.
- Count held at 12 for 5 samples -> ALARM after 3rd full sample. Then `ack`=1 for one edge with count still 12 -> state=2, ALARM again after 3 more full samples.
- Count 7 -> 0 (upstream reset) -> `drop_pulse`=1 for one cycle, `wrap_pulse`=0, `cycles` unchanged, state=IDLE.
- Timer 0..27,0 repeated 300 times -> `tick_pulse` every 28 cycles, `frames` saturates at 255. Count and timer both wrap after 364 cycles from aligned zero -> both pulses in the same cycle.
- Inject count_in=14 for one sample, then normal values -> `error`=1 and stays 1 until `reset` low.
- Assert `reset` low asynchronously while in ALARM with `cycles`=4 -> all outputs 0 immediately. After release with count_in=0, no pulses.
